cpu_lsu: RTL and testbench
==========================

// Module: cpu_lsu
// PURPOSE
//  Parametrised load/store unit between the CPU sequencer and all data-space targets.
//  Replaces the inline MEMR/MEMW handling with one request/response engine.
//  Targets: SDRAM controller (handshake with busy/rd_ready, timeout), bootloader ROM window (sync ROM)
//  and VGA framebuffer window, all in the config space.
//  Returns read data or an error flag per request.
// PARAMETERS
//  DATA_W      16       data/address width of CPU side; addr[DATA_W-1]=1 selects config space
//  MEM_ADDR_W  25       SDRAM controller address width; CPU address zero-extended
//  ROM_BASE    'hD000   first config address of bootloader ROM window
//  ROM_DEPTH   2048     ROM window size in words
//  ROM_AW      11       ROM address width, clog2(ROM_DEPTH)
//  FB_BASE     'hE000   first config address of framebuffer window
//  FB_DEPTH    4800     framebuffer window size in bytes
//  FB_AW       13       framebuffer address width
//  FB_DW       8        framebuffer data width; low FB_DW bits of wdata are written
//  TIMEOUT     255      max cycles waiting on SDRAM before an error response
// PORTS
//  clk           in   1           system clock
//  rst           in   1           synchronous, active-high reset
//  req_valid     in   1           request strobe; sampled only while req_ready=1
//  req_ready     out  1           high iff FSM in IDLE
//  req_write     in   1           1=store, 0=load
//  req_addr      in   DATA_W      data-space address
//  req_wdata     in   DATA_W      store data
//  resp_valid    out  1           one-cycle completion pulse, no backpressure
//  resp_rdata    out  DATA_W      load data, valid with resp_valid (0 for stores/errors)
//  resp_err      out  1           valid with resp_valid: timeout or unmapped/illegal access
//  mem_rd        out  1           SDRAM read request
//  mem_wr        out  1           SDRAM write request
//  mem_addr      out  MEM_ADDR_W  SDRAM address, held stable while mem_rd/mem_wr high
//  mem_wdata     out  DATA_W      SDRAM write data
//  mem_rdata     in   DATA_W      SDRAM read data, valid when mem_rd_ready
//  mem_rd_ready  in   1           SDRAM read data strobe (may be a single-cycle pulse)
//  mem_busy      in   1           SDRAM controller busy
//  rom_addr      out  ROM_AW      ROM word address; rom_data valid the following cycle
//  rom_data      in   DATA_W      ROM read data
//  fb_we         out  1           framebuffer write strobe, single cycle
//  fb_addr       out  FB_AW       framebuffer address
//  fb_data       out  FB_DW       framebuffer data
// BEHAVIOUR
//  Reset: all outputs 0, except req_ready=1; FSM IDLE; timeout counter and rd_ready latch cleared.
//  Decode in IDLE on req_valid (accept edge T); request fields registered at T:
//   addr MSB=0               -> SDRAM (RD_REQ or WR_REQ)
//   load  in [ROM_BASE,+ROM_DEPTH) -> ROM_ADDR
//   store in [FB_BASE,+FB_DEPTH)   -> FB_WR
//   any other config access (incl. store to ROM) -> RESP with err=1, no side effects
//  States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ROM_ADDR, ROM_CAPT, FB_WR, RESP.
//  RD_REQ:
//   - mem_rd=1, mem_addr held
//   - go to RD_WAIT when mem_busy=1 or rd_ready latch set
//  RD_WAIT:
//   - mem_rd=0
//   - rd_ready latch: set by mem_rd_ready only in RD_REQ/RD_WAIT; on set, capture mem_rdata
//   - go to RESP once latch set
//  WR_REQ:
//   - mem_wr=1, mem_addr/mem_wdata held
//   - go to WR_WAIT when mem_busy=1
//  WR_WAIT:
//   - mem_wr=0
//   - go to RESP when mem_busy=0
//  Timeout: counter runs in RD_REQ..WR_WAIT; at TIMEOUT -> RESP with err=1, mem_rd/mem_wr dropped.
//  ROM: rom_addr=addr-ROM_BASE driven in ROM_ADDR; data captured in ROM_CAPT; resp_valid at T+3.
//  FB:
//   - fb_we=1 one cycle at T+1, fb_addr=addr-FB_BASE, fb_data=wdata[FB_DW-1:0]
//   - resp_valid at T+2
//  RESP: resp_valid=1 one cycle, then IDLE; req_ready=0 in RESP (no back-to-back in same cycle).
//  Width: address subtraction in DATA_W, truncated to ROM_AW/FB_AW; window end bound is exclusive.
//  mem_rd_ready arriving in IDLE/other states is ignored and not latched.
//  Reset mid-transaction: abandon, outputs to reset values next edge, no resp_valid issued.
// TESTING
//  ROM load: req addr=D005, rom[5]=1234 -> resp_valid at T+3, rdata=1234, err=0.
//  FB store: addr=E010, wdata=ABCD -> fb_we pulse at T+1, fb_addr=0010, fb_data=CD; resp at T+2.
//  SDRAM read with 1-cycle rd_ready pulse during RD_REQ (busy never high)
//   -> data latched, rdata correct, one resp.
//  SDRAM write, busy held high 300 cycles -> resp_err=1 after TIMEOUT, mem_wr low, req_ready back.
//  Store to D000, load from F2C0 -> immediate err=1; no fb_we, no mem_rd/mem_wr.
//  rst asserted in RD_WAIT -> next edge IDLE, no resp_valid; late mem_rd_ready ignored.

Source files
------------

// File: rtl/cpu_lsu.sv
// Load/store unit: one request/response engine in front of SDRAM, the bootloader
// ROM window and the framebuffer window. Each accepted request yields one response.
module cpu_lsu #(
   parameter int DATA_W     = 16,
   parameter int MEM_ADDR_W = 25,
   parameter int ROM_BASE   = 'hD000,
   parameter int ROM_DEPTH  = 2048,
   parameter int ROM_AW     = 11,
   parameter int FB_BASE    = 'hE000,
   parameter int FB_DEPTH   = 4800,
   parameter int FB_AW      = 13,
   parameter int FB_DW      = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [DATA_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_rd_ready,
   input  logic                  mem_busy,
   output logic [ROM_AW-1:0]     rom_addr,
   input  logic [DATA_W-1:0]     rom_data,
   output logic                  fb_we,
   output logic [FB_AW-1:0]      fb_addr,
   output logic [FB_DW-1:0]      fb_data
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Window bounds carry one extra bit so BASE+DEPTH cannot wrap.
   localparam logic [DATA_W:0] ROM_LO = (DATA_W+1)'(ROM_BASE);
   localparam logic [DATA_W:0] ROM_HI = (DATA_W+1)'(ROM_BASE + ROM_DEPTH);
   localparam logic [DATA_W:0] FB_LO  = (DATA_W+1)'(FB_BASE);
   localparam logic [DATA_W:0] FB_HI  = (DATA_W+1)'(FB_BASE + FB_DEPTH);

   typedef enum logic [3:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ROM_ADDR, ROM_CAPT, FB_WR, RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state, state_nxt;
   req_t              req_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q, err_nxt;
   logic              rd_rdy_q;
   logic [CNT_W-1:0]  tmo_cnt;
   logic              tmo_hit, mem_phase, rd_phase;
   logic [DATA_W:0]   addr_x;
   logic              hit_rom, hit_fb;

   assign addr_x    = {1'b0, req_addr};
   assign hit_rom   = req_addr[DATA_W-1] && !req_write && addr_x >= ROM_LO && addr_x < ROM_HI;
   assign hit_fb    = req_addr[DATA_W-1] &&  req_write && addr_x >= FB_LO  && addr_x < FB_HI;
   assign mem_phase = state inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT};
   assign rd_phase  = state inside {RD_REQ, RD_WAIT};
   assign tmo_hit   = tmo_cnt == CNT_W'(TIMEOUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         req_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         rd_rdy_q <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         err_q   <= err_nxt;
         tmo_cnt <= mem_phase ? tmo_cnt + 1'b1 : '0;
         if (state == IDLE) begin
            rd_rdy_q <= 1'b0;
            if (req_valid) begin
               req_q   <= '{write: req_write, addr: req_addr, wdata: req_wdata};
               rdata_q <= '0;
            end
         end else if (rd_phase && mem_rd_ready && !rd_rdy_q) begin
            // Read strobe may be a single cycle; hold it until the FSM consumes it.
            rd_rdy_q <= 1'b1;
            rdata_q  <= mem_rdata;
         end else if (state == ROM_CAPT) begin
            rdata_q <= rom_data;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      case (state)
         IDLE: if (req_valid) begin
            if (!req_addr[DATA_W-1]) state_nxt = req_write ? WR_REQ : RD_REQ;
            else if (hit_rom)        state_nxt = ROM_ADDR;
            else if (hit_fb)         state_nxt = FB_WR;
            else begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end
         end
         RD_REQ: begin
            if (tmo_hit) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end else if (mem_busy || rd_rdy_q) state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (tmo_hit) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end else if (rd_rdy_q) state_nxt = RESP;
         end
         WR_REQ: begin
            if (tmo_hit) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end else if (mem_busy) state_nxt = WR_WAIT;
         end
         WR_WAIT: begin
            if (tmo_hit) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end else if (!mem_busy) state_nxt = RESP;
         end
         ROM_ADDR: state_nxt = ROM_CAPT;
         ROM_CAPT: state_nxt = RESP;
         FB_WR:    state_nxt = RESP;
         RESP:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign req_ready  = state == IDLE;
   assign resp_valid = state == RESP;
   assign resp_err   = (state == RESP) && err_q;
   assign resp_rdata = (state == RESP && !err_q) ? rdata_q : '0;

   assign mem_rd    = state == RD_REQ;
   assign mem_wr    = state == WR_REQ;
   assign mem_addr  = MEM_ADDR_W'(req_q.addr);
   assign mem_wdata = req_q.wdata;

   assign rom_addr = (state == ROM_ADDR) ? ROM_AW'(req_q.addr - ROM_LO[DATA_W-1:0]) : '0;
   assign fb_we    = state == FB_WR;
   assign fb_addr  = (state == FB_WR) ? FB_AW'(req_q.addr - FB_LO[DATA_W-1:0]) : '0;
   assign fb_data  = (state == FB_WR) ? req_q.wdata[FB_DW-1:0] : '0;

endmodule

// File: tb/tb_cpu_lsu.sv
// Bench for cpu_lsu: directed vector table, randomized requests against a
// request-level reference model, and hand sequences for SDRAM corner cases.
module tb_cpu_lsu;

   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [15:0] resp_rdata;
   logic        mem_rd, mem_wr, mem_rd_ready, mem_busy;
   logic [24:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [10:0] rom_addr;
   logic [15:0] rom_data;
   logic        fb_we;
   logic [12:0] fb_addr;
   logic [7:0]  fb_data;

   always #5 clk = ~clk;

   cpu_lsu dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rd_ready(mem_rd_ready), .mem_busy(mem_busy),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
   );

   // Sync ROM behind the window
   logic [15:0] rom_mem [2048];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   function automatic logic [15:0] sdram_init(input int i);
      return 16'(i * 16'h0101) ^ 16'h5A3C;
   endfunction

   // SDRAM device: busy for a few cycles after each request, read data strobed as busy drops
   logic        sdr_auto, t_busy, t_rdy;
   logic [15:0] t_rdata;
   logic        m_busy, m_rdy, pend_rd;
   logic [15:0] m_rdata;
   logic [5:0]  paddr;
   int          bcnt;
   logic [15:0] dev [64];

   assign mem_busy     = sdr_auto ? m_busy  : t_busy;
   assign mem_rd_ready = sdr_auto ? m_rdy   : t_rdy;
   assign mem_rdata    = sdr_auto ? m_rdata : t_rdata;

   always @(posedge clk) begin
      m_rdy <= 1'b0;
      if (rst) begin
         m_busy  <= 1'b0;
         bcnt    <= 0;
         pend_rd <= 1'b0;
         m_rdata <= '0;
         for (int i = 0; i < 64; i++) dev[i] <= sdram_init(i);
      end else if (m_busy) begin
         if (bcnt == 0) begin
            m_busy <= 1'b0;
            if (pend_rd) begin
               m_rdy   <= 1'b1;
               m_rdata <= dev[paddr];
            end
            pend_rd <= 1'b0;
         end else bcnt <= bcnt - 1;
      end else if (sdr_auto && (mem_rd || mem_wr)) begin
         m_busy  <= 1'b1;
         bcnt    <= int'($urandom_range(3, 0));
         pend_rd <= mem_rd;
         paddr   <= mem_addr[5:0];
         if (mem_wr) dev[mem_addr[5:0]] <= mem_wdata;
      end
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request and watch the outputs until its response (plus one cycle).
   task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] d, input int lim,
                       output int rlat, output logic [15:0] rd, output logic er,
                       output int nfb, output logic [12:0] fa, output logic [7:0] fd,
                       output int nmem, output int nresp, output logic rdy_after);
      int k;
      rlat = 0; rd = '0; er = 1'b0; nfb = 0; fa = '0; fd = '0; nmem = 0; nresp = 0;
      @(negedge clk);
      k = 0;
      while (!req_ready && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (k >= lim) chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 1; i <= lim && nresp == 0; i++) begin
         @(negedge clk);
         if (fb_we) begin
            nfb++;
            fa = fb_addr;
            fd = fb_data;
         end
         if (mem_rd || mem_wr) nmem++;
         if (resp_valid) begin
            nresp++;
            rlat = i;
            rd   = resp_rdata;
            er   = resp_err;
         end
      end
      @(negedge clk);
      if (resp_valid) nresp++;
      rdy_after = req_ready;
   endtask

   // exp_lat == 0 marks an SDRAM access (latency depends on the device).
   task automatic run_chk(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input logic exp_err, input int exp_lat,
                          input int exp_nfb, input logic [12:0] exp_fa, input logic [7:0] exp_fd);
      int rlat, nfb, nmem, nresp;
      logic [15:0] rd;
      logic er, rdy_after;
      logic [12:0] fa;
      logic [7:0] fd;
      xact(w, a, d, 40, rlat, rd, er, nfb, fa, fd, nmem, nresp, rdy_after);
      chk({tag, "_nresp"}, 32'(nresp), 32'd1);
      chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
      chk({tag, "_err"}, 32'(er), 32'(exp_err));
      chk({tag, "_ready"}, 32'(rdy_after), 32'd1);
      chk({tag, "_nfb"}, 32'(nfb), 32'(exp_nfb));
      if (exp_nfb == 1) begin
         chk({tag, "_fb_addr"}, 32'(fa), 32'(exp_fa));
         chk({tag, "_fb_data"}, 32'(fd), 32'(exp_fd));
      end
      if (exp_lat == 0) chk({tag, "_mem_used"}, 32'(nmem > 0), 32'd1);
      else begin
         chk({tag, "_lat"}, 32'(rlat), 32'(exp_lat));
         chk({tag, "_no_mem"}, 32'(nmem), 32'd0);
      end
   endtask

   typedef struct {
      logic        w;
      logic [15:0] a, d, rd;
      logic        err;
      int          lat, nfb;
      logic [12:0] fa;
      logic [7:0]  fd;
   } vec_t;

   vec_t        vt [15];
   logic [15:0] ref_sdram [64];
   logic [15:0] edges [8];

   initial begin
      int rlat, nresp;
      logic [15:0] rd;
      logic er, wr_at, rdy_after;

      sdr_auto = 1'b1; t_busy = 1'b0; t_rdy = 1'b0; t_rdata = '0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 2048; i++) rom_mem[i] = 16'($urandom);
      rom_mem[0] = 16'h0BAD; rom_mem[5] = 16'h1234; rom_mem[2047] = 16'hC0DE;
      for (int i = 0; i < 64; i++) ref_sdram[i] = sdram_init(i);
      edges = '{16'hCFFF, 16'hD000, 16'hD7FF, 16'hD800, 16'hDFFF, 16'hE000, 16'hF2BF, 16'hF2C0};

      //          w     addr      wdata     rdata     err   lat nfb fa        fd
      vt[0]  = '{1'b0, 16'hD005, 16'h0000, 16'h1234, 1'b0, 3, 0, 13'h0000, 8'h00};
      vt[1]  = '{1'b1, 16'hE010, 16'hABCD, 16'h0000, 1'b0, 2, 1, 13'h0010, 8'hCD};
      vt[2]  = '{1'b1, 16'hD000, 16'h1111, 16'h0000, 1'b1, 1, 0, 13'h0000, 8'h00};
      vt[3]  = '{1'b0, 16'hF2C0, 16'h0000, 16'h0000, 1'b1, 1, 0, 13'h0000, 8'h00};
      vt[4]  = '{1'b0, 16'hD000, 16'h0000, 16'h0BAD, 1'b0, 3, 0, 13'h0000, 8'h00};
      vt[5]  = '{1'b0, 16'hD7FF, 16'h0000, 16'hC0DE, 1'b0, 3, 0, 13'h0000, 8'h00};
      vt[6]  = '{1'b0, 16'hD800, 16'h0000, 16'h0000, 1'b1, 1, 0, 13'h0000, 8'h00};
      vt[7]  = '{1'b1, 16'hE000, 16'h005A, 16'h0000, 1'b0, 2, 1, 13'h0000, 8'h5A};
      vt[8]  = '{1'b1, 16'hF2BF, 16'h1277, 16'h0000, 1'b0, 2, 1, 13'h12BF, 8'h77};
      vt[9]  = '{1'b1, 16'hF2C0, 16'h3344, 16'h0000, 1'b1, 1, 0, 13'h0000, 8'h00};
      vt[10] = '{1'b0, 16'hE010, 16'h0000, 16'h0000, 1'b1, 1, 0, 13'h0000, 8'h00};
      vt[11] = '{1'b0, 16'hCFFF, 16'h0000, 16'h0000, 1'b1, 1, 0, 13'h0000, 8'h00};
      vt[12] = '{1'b1, 16'h0021, 16'h0123, 16'h0000, 1'b0, 0, 0, 13'h0000, 8'h00};
      vt[13] = '{1'b0, 16'h0021, 16'h0000, 16'h0123, 1'b0, 0, 0, 13'h0000, 8'h00};
      vt[14] = '{1'b1, 16'h8000, 16'h9999, 16'h0000, 1'b1, 1, 0, 13'h0000, 8'h00};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      chk("rst_mem_rdwr", 32'({mem_rd, mem_wr}), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_fb", 32'({fb_we, fb_addr, fb_data}), 32'd0);

      for (int i = 0; i < 15; i++)
         run_chk($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d, vt[i].rd, vt[i].err,
                 vt[i].lat, vt[i].nfb, vt[i].fa, vt[i].fd);
      ref_sdram[6'h21] = 16'h0123;  // table store above

      for (int n = 0; n < 150; n++) begin
         logic w, eerr;
         logic [15:0] a, d, erd;
         logic [12:0] efa;
         logic [7:0] efd;
         int elat, enfb, ia;
         case ($urandom_range(4, 0))
            0:       a = {1'b0, 15'($urandom)};
            1:       a = 16'hD000 + 16'($urandom_range(2047, 0));
            2:       a = 16'hE000 + 16'($urandom_range(4799, 0));
            3:       a = edges[$urandom_range(7, 0)];
            default: a = {1'b1, 15'($urandom)};
         endcase
         w = 1'($urandom);
         d = 16'($urandom);
         ia = int'(a);
         erd = '0; eerr = 1'b0; efa = '0; efd = '0; enfb = 0;
         if (!a[15]) begin
            elat = 0;
            if (w) ref_sdram[a[5:0]] = d;
            else   erd = ref_sdram[a[5:0]];
         end else if (!w && ia >= 'hD000 && ia < 'hD000 + 2048) begin
            elat = 3;
            erd  = rom_mem[ia - 'hD000];
         end else if (w && ia >= 'hE000 && ia < 'hE000 + 4800) begin
            elat = 2;
            enfb = 1;
            efa  = 13'(ia - 'hE000);
            efd  = d[7:0];
         end else begin
            elat = 1;
            eerr = 1'b1;
         end
         run_chk($sformatf("rnd%0d_%s_%h", n, w ? "st" : "ld", a), w, a, d, erd, eerr, elat, enfb, efa, efd);
      end

      // SDRAM read with a single-cycle rd_ready while still in the request phase
      sdr_auto = 1'b0; t_busy = 1'b0; t_rdy = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0042;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("pulse_mem_rd", 32'(mem_rd), 32'd1);
      chk("pulse_mem_addr", 32'(mem_addr), 32'h42);
      t_rdy = 1'b1; t_rdata = 16'hBEEF;
      @(negedge clk);
      t_rdy = 1'b0; t_rdata = '0;
      nresp = 0; rd = '0; er = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            nresp++;
            rd = resp_rdata;
            er = resp_err;
         end
      end
      chk("pulse_nresp", 32'(nresp), 32'd1);
      chk("pulse_rdata", 32'(rd), 32'hBEEF);
      chk("pulse_err", 32'(er), 32'd0);

      // SDRAM write with busy stuck high: timeout error
      t_busy = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0100; req_wdata = 16'h7777;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("tmo_mem_wr", 32'(mem_wr), 32'd1);
      chk("tmo_mem_wdata", 32'(mem_wdata), 32'h7777);
      chk("tmo_mem_addr", 32'(mem_addr), 32'h100);
      rlat = 0; nresp = 0; er = 1'b0; wr_at = 1'b1; rdy_after = 1'b0;
      for (int i = 2; i <= 400; i++) begin
         @(negedge clk);
         if (i == 301) t_busy = 1'b0;
         if (resp_valid) begin
            nresp++;
            if (rlat == 0) begin
               rlat  = i;
               er    = resp_err;
               wr_at = mem_wr;
            end
         end
         if (rlat != 0 && i == rlat + 1) rdy_after = req_ready;
      end
      chk("tmo_nresp", 32'(nresp), 32'd1);
      chk("tmo_err", 32'(er), 32'd1);
      chk("tmo_lat_window", 32'(rlat >= TIMEOUT && rlat <= TIMEOUT + 3), 32'd1);
      chk("tmo_mem_wr_low", 32'(wr_at), 32'd0);
      chk("tmo_ready_back", 32'(rdy_after), 32'd1);

      // Reset while waiting on a read, then a late rd_ready that must be ignored
      t_busy = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid_rd_wait_mem_rd", 32'(mem_rd), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_ready", 32'(req_ready), 32'd1);
      chk("rstmid_mem_addr", 32'(mem_addr), 32'd0);
      chk("rstmid_resp", 32'(resp_valid), 32'd0);
      t_busy = 1'b0; t_rdy = 1'b1; t_rdata = 16'hDEAD;
      @(negedge clk);
      t_rdy = 1'b0; t_rdata = '0;
      nresp = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid) nresp++;
      end
      chk("rstmid_no_resp", 32'(nresp), 32'd0);

      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0003;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("stale_latch_mem_rd", 32'(mem_rd), 32'd1);
      chk("stale_latch_resp", 32'(resp_valid), 32'd0);
      t_rdy = 1'b1; t_rdata = 16'h5A5A;
      @(negedge clk);
      t_rdy = 1'b0; t_rdata = '0;
      nresp = 0; rd = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            nresp++;
            rd = resp_rdata;
         end
      end
      chk("after_rst_nresp", 32'(nresp), 32'd1);
      chk("after_rst_rdata", 32'(rd), 32'h5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
